// File: rtl/mem_access_sequencer_if.sv
// Data-memory port between the MEM-stage sequencer and the memory.
// Request is valid/ready; the read response is a single valid strobe.
interface mem_access_sequencer_if;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic        dmem_req_we;
  logic [31:0] dmem_req_addr;
  logic [31:0] dmem_req_wdata;
  logic [3:0]  dmem_req_be;
  logic        dmem_resp_valid;
  logic [31:0] dmem_resp_rdata;

  modport master (
    output dmem_req_valid,
    output dmem_req_we,
    output dmem_req_addr,
    output dmem_req_wdata,
    output dmem_req_be,
    input  dmem_req_ready,
    input  dmem_resp_valid,
    input  dmem_resp_rdata
  );

  modport slave (
    input  dmem_req_valid,
    input  dmem_req_we,
    input  dmem_req_addr,
    input  dmem_req_wdata,
    input  dmem_req_be,
    output dmem_req_ready,
    output dmem_resp_valid,
    output dmem_resp_rdata
  );
endinterface

// File: rtl/mem_access_sequencer.sv
// MEM-stage load/store sequencer: one bus transaction per access,
// lane formatting, misalignment detection and response timeout.
module mem_access_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  input  logic        flush,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  mem_load_type,
  input  logic [1:0]  mem_store_type,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  mem_access_sequencer_if.master dmem,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_data_valid,
  output logic        misaligned_exc,
  output logic        bus_err
);

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b011;
  localparam logic [2:0] LHU = 3'b100;
  localparam logic [2:0] LNONE = 3'b111;
  localparam logic [1:0] SB  = 2'b00;
  localparam logic [1:0] SH  = 2'b01;
  localparam logic [1:0] SW  = 2'b10;
  localparam logic [1:0] SNONE = 2'b11;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE, REQ, WAIT, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] ld_q, ld_d;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [2:0]  lt_q;
  logic [1:0]  off_q;

  logic        legal;
  logic        mis;
  logic        capture;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] ext;

  assign legal = op_valid & ~flush &
    (mem_write ? (mem_store_type != SNONE)
               : (mem_read & (mem_load_type != LNONE)));

  always_comb begin
    mis = 1'b0;
    if (mem_write)
      mis = ((mem_store_type == SH) & addr[0]) |
            ((mem_store_type == SW) & (|addr[1:0]));
    else
      mis = (((mem_load_type == LH) | (mem_load_type == LHU))
             & addr[0]) |
            ((mem_load_type == LW) & (|addr[1:0]));
  end

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = store_data;
    unique case (1'b1)
      mem_store_type == SB: begin
        be_d    = 4'b0001 << addr[1:0];
        wdata_d = {4{store_data[7:0]}};
      end
      mem_store_type == SH: begin
        be_d    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{store_data[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = store_data;
      end
    endcase
  end

  // Lane select uses the offset captured at acceptance, not live addr.
  always_comb begin
    rbyte = dmem.dmem_resp_rdata[7:0];
    unique case (off_q)
      2'd1:    rbyte = dmem.dmem_resp_rdata[15:8];
      2'd2:    rbyte = dmem.dmem_resp_rdata[23:16];
      2'd3:    rbyte = dmem.dmem_resp_rdata[31:24];
      default: rbyte = dmem.dmem_resp_rdata[7:0];
    endcase
    rhalf = off_q[1] ? dmem.dmem_resp_rdata[31:16]
                     : dmem.dmem_resp_rdata[15:0];
    unique case (lt_q)
      LB:      ext = {{24{rbyte[7]}}, rbyte};
      LBU:     ext = {24'd0, rbyte};
      LH:      ext = {{16{rhalf[15]}}, rhalf};
      LHU:     ext = {16'd0, rhalf};
      default: ext = dmem.dmem_resp_rdata;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    err_d           = err_q;
    ld_d            = ld_q;
    capture         = 1'b0;
    stall           = 1'b0;
    misaligned_exc  = 1'b0;
    load_data_valid = 1'b0;
    bus_err         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (legal) begin
          if (mis) begin
            misaligned_exc = 1'b1;
          end else begin
            stall   = 1'b1;
            capture = 1'b1;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        if (dmem.dmem_req_ready) begin
          err_d   = 1'b0;
          cnt_d   = 16'd0;
          state_d = we_q ? DONE : WAIT;
        end
      end
      WAIT: begin
        stall = 1'b1;
        cnt_d = cnt_q + 16'd1;
        if (dmem.dmem_resp_valid) begin
          ld_d    = ext;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        load_data_valid = ~we_q & ~err_q;
        bus_err         = err_q;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      err_q   <= 1'b0;
      ld_q    <= 32'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      lt_q    <= 3'd0;
      off_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ld_q    <= ld_d;
      if (capture) begin
        we_q    <= mem_write;
        addr_q  <= {addr[31:2], 2'b00};
        wdata_q <= mem_write ? wdata_d : 32'd0;
        be_q    <= mem_write ? be_d : 4'd0;
        lt_q    <= mem_load_type;
        off_q   <= addr[1:0];
      end
    end
  end

  assign dmem.dmem_req_valid = (state_q == REQ);
  assign dmem.dmem_req_we    = we_q;
  assign dmem.dmem_req_addr  = addr_q;
  assign dmem.dmem_req_wdata = wdata_q;
  assign dmem.dmem_req_be    = be_q;
  assign load_data           = ld_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer: vector table plus
// hand-written reset-abort sequence.
module tb_mem_access_sequencer;

  logic        clk;
  logic        rst_n;
  logic        op_valid;
  logic        flush;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  mem_load_type;
  logic [1:0]  mem_store_type;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        stall;
  logic [31:0] load_data;
  logic        load_data_valid;
  logic        misaligned_exc;
  logic        bus_err;

  mem_access_sequencer_if bus ();

  mem_access_sequencer #(.TIMEOUT_CYCLES(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .op_valid       (op_valid),
    .flush          (flush),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_load_type  (mem_load_type),
    .mem_store_type (mem_store_type),
    .addr           (addr),
    .store_data     (store_data),
    .dmem           (bus.master),
    .stall          (stall),
    .load_data      (load_data),
    .load_data_valid(load_data_valid),
    .misaligned_exc (misaligned_exc),
    .bus_err        (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic        fl;
    logic        fl_after;
    logic [2:0]  lt;
    logic [1:0]  st;
    logic [31:0] a;
    logic [31:0] sd;
    logic [31:0] rdata;
    int          rdly;
    int          lat;
    int          e_stall;
    int          e_hs;
    logic        e_we;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    int          e_ldv;
    logic [31:0] e_ld;
    int          e_mis;
    int          e_err;
  } vec_t;

  vec_t        vq[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] last_ld = 32'd0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h",
               name, act, exp);
    end
  endtask

  task automatic add_st(input logic rd, input logic [1:0] st,
                        input logic [31:0] a, input logic [31:0] sd,
                        input int rdly, input logic fl_after,
                        input logic [31:0] e_addr,
                        input logic [3:0] e_be,
                        input logic [31:0] e_wdata,
                        input int e_stall);
    vec_t v;
    v = '{rd: rd, wr: 1'b1, fl: 1'b0, fl_after: fl_after,
          lt: 3'b010, st: st, a: a, sd: sd, rdata: 32'd0,
          rdly: rdly, lat: 0, e_stall: e_stall, e_hs: 1,
          e_we: 1'b1, e_addr: e_addr, e_be: e_be,
          e_wdata: e_wdata, e_ldv: 0, e_ld: 32'd0,
          e_mis: 0, e_err: 0};
    vq.push_back(v);
  endtask

  task automatic add_ld(input logic [2:0] lt, input logic [31:0] a,
                        input logic [31:0] rdata, input int lat,
                        input logic [31:0] e_addr,
                        input logic [31:0] e_ld,
                        input int e_stall, input int e_err);
    vec_t v;
    v = '{rd: 1'b1, wr: 1'b0, fl: 1'b0, fl_after: 1'b0,
          lt: lt, st: 2'b11, a: a, sd: 32'h5555_AAAA,
          rdata: rdata, rdly: 0, lat: lat, e_stall: e_stall,
          e_hs: 1, e_we: 1'b0, e_addr: e_addr, e_be: 4'd0,
          e_wdata: 32'd0, e_ldv: (e_err != 0) ? 0 : 1,
          e_ld: e_ld, e_mis: 0, e_err: e_err};
    vq.push_back(v);
  endtask

  task automatic add_nop(input logic rd, input logic wr,
                         input logic [2:0] lt, input logic [1:0] st,
                         input logic [31:0] a, input logic fl,
                         input int e_mis);
    vec_t v;
    v = '{rd: rd, wr: wr, fl: fl, fl_after: 1'b0, lt: lt, st: st,
          a: a, sd: 32'h1234_5678, rdata: 32'd0, rdly: 0, lat: 1,
          e_stall: 0, e_hs: 0, e_we: 1'b0, e_addr: 32'd0,
          e_be: 4'd0, e_wdata: 32'd0, e_ldv: 0, e_ld: 32'd0,
          e_mis: e_mis, e_err: 0};
    vq.push_back(v);
  endtask

  task automatic run(input vec_t v, input int idx);
    int          n_stall = 0;
    int          n_hs    = 0;
    int          n_ldv   = 0;
    int          n_mis   = 0;
    int          n_err   = 0;
    int          n_rq    = 0;
    int          cd      = 0;
    int          bad     = 0;
    bit          done    = 1'b0;
    logic [31:0] ld_seen = 32'd0;
    string       tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    op_valid       = 1'b1;
    flush          = v.fl;
    mem_read       = v.rd;
    mem_write      = v.wr;
    mem_load_type  = v.lt;
    mem_store_type = v.st;
    addr           = v.a;
    store_data     = v.sd;
    for (int c = 0; c < 40 && !done; c++) begin
      if (c > 0) begin
        @(negedge clk);
        flush = v.fl_after;
        bus.dmem_resp_valid = 1'b0;
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            bus.dmem_resp_valid = 1'b1;
            bus.dmem_resp_rdata = v.rdata;
          end
        end
      end
      bus.dmem_req_ready = 1'b0;
      #1;
      if (bus.dmem_req_valid) begin
        bus.dmem_req_ready = (n_rq >= v.rdly);
        n_rq++;
        if (bus.dmem_req_addr !== v.e_addr) bad++;
        if (bus.dmem_req_we !== v.e_we) bad++;
        if (bus.dmem_req_be !== v.e_be) bad++;
        if (v.e_we && bus.dmem_req_wdata !== v.e_wdata) bad++;
        if (stall !== 1'b1) bad++;
      end
      #1;
      if (stall) n_stall++;
      if (misaligned_exc) n_mis++;
      if (bus_err) n_err++;
      if (load_data_valid) begin
        n_ldv++;
        ld_seen = load_data;
      end
      if (bus.dmem_req_valid && bus.dmem_req_ready) begin
        n_hs++;
        if (!v.e_we) cd = v.lat;
      end
      if (!stall) begin
        done     = 1'b1;
        op_valid = 1'b0;
        flush    = 1'b0;
      end
    end
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " stall_cycles"}, n_stall, v.e_stall);
    chk({tag, " handshakes"}, n_hs, v.e_hs);
    chk({tag, " misaligned"}, n_mis, v.e_mis);
    chk({tag, " bus_err"}, n_err, v.e_err);
    chk({tag, " load_valid"}, n_ldv, v.e_ldv);
    if (v.e_hs != 0) chk({tag, " req_fields_bad"}, bad, 0);
    if (v.e_ldv != 0) begin
      chk({tag, " load_data"}, ld_seen, v.e_ld);
      last_ld = v.e_ld;
    end
    chk({tag, " load_held"}, load_data, last_ld);
  endtask

  task automatic chk_zero(input string name);
    chk(name, {stall, load_data_valid, misaligned_exc, bus_err,
               bus.dmem_req_valid, bus.dmem_req_we,
               bus.dmem_req_be}, 32'd0);
    chk({name, " addr"}, bus.dmem_req_addr, 32'd0);
    chk({name, " wdata"}, bus.dmem_req_wdata, 32'd0);
    chk({name, " load_data"}, load_data, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    op_valid = 1'b0;
    flush = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    mem_load_type = 3'b111;
    mem_store_type = 2'b11;
    addr = 32'd0;
    store_data = 32'd0;
    bus.dmem_req_ready = 1'b0;
    bus.dmem_resp_valid = 1'b0;
    bus.dmem_resp_rdata = 32'd0;

    add_st(1'b0, 2'b10, 32'h100, 32'hDEADBEEF, 0, 1'b0,
           32'h100, 4'b1111, 32'hDEADBEEF, 2);
    add_st(1'b0, 2'b00, 32'h203, 32'h000000A5, 0, 1'b0,
           32'h200, 4'b1000, 32'hA5A5A5A5, 2);
    add_st(1'b0, 2'b01, 32'h202, 32'h00001234, 0, 1'b0,
           32'h200, 4'b1100, 32'h12341234, 2);
    add_ld(3'b000, 32'h3, 32'h80FF7F01, 1, 32'h0,
           32'hFFFFFF80, 3, 0);
    add_ld(3'b011, 32'h3, 32'h80FF7F01, 1, 32'h0,
           32'h00000080, 3, 0);
    add_ld(3'b001, 32'h2, 32'h80FF7F01, 1, 32'h0,
           32'hFFFF80FF, 3, 0);
    add_ld(3'b100, 32'h0, 32'h80FF7F01, 1, 32'h0,
           32'h00007F01, 3, 0);
    add_ld(3'b010, 32'h4, 32'h12345678, 1, 32'h4,
           32'h12345678, 3, 0);
    add_st(1'b0, 2'b00, 32'h101, 32'h0000005A, 5, 1'b0,
           32'h100, 4'b0010, 32'h5A5A5A5A, 7);
    add_ld(3'b010, 32'h8, 32'h0, 0, 32'h8, 32'h0, 6, 1);
    add_nop(1'b1, 1'b0, 3'b010, 2'b11, 32'h102, 1'b0, 1);
    add_nop(1'b0, 1'b1, 3'b111, 2'b01, 32'h101, 1'b0, 1);
    add_nop(1'b1, 1'b0, 3'b000, 2'b11, 32'h1, 1'b1, 0);
    add_nop(1'b0, 1'b1, 3'b111, 2'b11, 32'h2, 1'b0, 0);
    add_nop(1'b1, 1'b0, 3'b111, 2'b11, 32'h0, 1'b0, 0);
    add_nop(1'b1, 1'b0, 3'b001, 2'b11, 32'h1, 1'b0, 1);
    add_st(1'b1, 2'b10, 32'h10, 32'h11223344, 0, 1'b0,
           32'h10, 4'b1111, 32'h11223344, 2);
    add_ld(3'b000, 32'h0, 32'h000000FE, 3, 32'h0,
           32'hFFFFFFFE, 5, 0);
    add_ld(3'b010, 32'hC, 32'hA1B2C3D4, 4, 32'hC,
           32'hA1B2C3D4, 6, 0);
    add_st(1'b0, 2'b10, 32'h20, 32'h0BADF00D, 2, 1'b1,
           32'h20, 4'b1111, 32'h0BADF00D, 4);
    add_st(1'b0, 2'b01, 32'h300, 32'hFFFF9876, 0, 1'b0,
           32'h300, 4'b0011, 32'h98769876, 2);

    @(negedge clk);
    @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) run(vq[i], i);

    // Abort a load mid-WAIT with reset, then run a clean load.
    @(negedge clk);
    op_valid = 1'b1;
    mem_read = 1'b1;
    mem_write = 1'b0;
    mem_load_type = 3'b010;
    mem_store_type = 2'b11;
    addr = 32'h40;
    @(negedge clk);
    bus.dmem_req_ready = 1'b1;
    @(negedge clk);
    bus.dmem_req_ready = 1'b0;
    op_valid = 1'b0;
    #1;
    chk("wait_stall", {31'd0, stall}, 32'd1);
    chk("wait_addr", bus.dmem_req_addr, 32'h40);
    #1;
    rst_n = 1'b0;
    #1;
    chk_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    last_ld = 32'd0;
    begin
      vec_t v;
      v = vq[7];
      v.a = 32'h0;
      v.e_addr = 32'h0;
      v.rdata = 32'hCAFEF00D;
      v.e_ld = 32'hCAFEF00D;
      run(v, 99);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
